// File: rtl/mem_arbiter.sv
// Two-requester (IFU read-only, LSU read/write) arbiter for a single memory port.
// Fixed LSU-over-IFU priority by default; define MEM_ARB_RR_EN for round-robin.
module mem_arbiter #(
    parameter int unsigned LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [7:0]  lsu_req_wmask,
    input  logic [63:0] lsu_req_wdata,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_resp_data,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam logic       OWN_IFU  = 1'b0;
    localparam logic       OWN_LSU  = 1'b1;
    localparam logic [7:0] CNT_INIT = (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

    state_t      r_state;
    state_t      w_next;
    logic        r_owner;
    logic        r_wen;
    logic        r_last_grant;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic [7:0]  r_wmask;
    logic [7:0]  r_cnt;

    logic w_idle;
    logic w_grant_lsu;
    logic w_accept;
    logic w_resp_hs;

    // Readies must read 0 while reset is held, even if requesters are valid.
    assign w_idle = (r_state == S_IDLE) && reset_n;

`ifdef MEM_ARB_RR_EN
    assign w_grant_lsu = lsu_req_valid && (!ifu_req_valid || (r_last_grant == OWN_IFU));
`else
    logic w_unused_last_grant;
    assign w_grant_lsu         = lsu_req_valid;
    assign w_unused_last_grant = r_last_grant;
`endif

    assign w_accept  = w_idle && (ifu_req_valid || lsu_req_valid);
    assign w_resp_hs = (r_state == S_RESP) &&
                       ((r_owner == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = (LATENCY == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (r_cnt == 8'd0) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            S_RESP:   if (w_resp_hs) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready  = w_idle && ifu_req_valid && !w_grant_lsu;
        lsu_req_ready  = w_idle && w_grant_lsu;
        ifu_resp_valid = (r_state == S_RESP) && (r_owner == OWN_IFU);
        lsu_resp_valid = (r_state == S_RESP) && (r_owner == OWN_LSU);
        ifu_resp_data  = r_rdata;
        lsu_resp_data  = r_rdata;
        mem_ren        = (r_state == S_ACCESS) && !r_wen;
        mem_wen        = (r_state == S_ACCESS) && r_wen;
        mem_addr       = r_addr;
        mem_wmask      = r_wmask;
        mem_wdata      = r_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_IFU;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wmask      <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_cnt        <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant_lsu;
                r_last_grant <= w_grant_lsu;
                r_addr       <= w_grant_lsu ? lsu_req_addr : ifu_req_addr;
                r_wen        <= w_grant_lsu && lsu_req_wen;
                r_wmask      <= w_grant_lsu ? lsu_req_wmask : 8'd0;
                r_wdata      <= w_grant_lsu ? lsu_req_wdata : 64'd0;
                r_cnt        <= CNT_INIT;
            end
            if ((r_state == S_WAIT) && (r_cnt != 8'd0))
                r_cnt <= r_cnt - 8'd1;
            if (r_state == S_ACCESS)
                r_rdata <= r_wen ? 64'd0 : mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (LATENCY 0,1,3,5) sharing one memory model,
// one instance driven at a time through sel.
module tb_mem_arbiter;
    localparam int NI = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  sel;
    logic        iv, irr, lv, lw, lrr;
    logic [63:0] ia, la, ld;
    logic [7:0]  lm;

    logic [NI-1:0] w_irdy, w_lrdy, w_ivld, w_lvld, w_ren, w_wen;
    logic [63:0]   w_idata [NI];
    logic [63:0]   w_ldata [NI];
    logic [63:0]   w_addr  [NI];
    logic [63:0]   w_wdata [NI];
    logic [63:0]   w_rdata [NI];
    logic [7:0]    w_wmask [NI];

    logic [63:0] mem [0:8191];
    int          strobes [NI] = '{default: 0};

    logic        o_irdy, o_lrdy, o_ivld, o_lvld, o_ren, o_wen;
    logic [63:0] o_idata, o_ldata, o_addr, o_wdata;
    logic [7:0]  o_wmask;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        mem_arbiter #(.LATENCY((k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 5)) u_dut (
            .clock          (clock),
            .reset_n        (reset_n),
            .ifu_req_valid  (iv && (sel == 2'(k))),
            .ifu_req_ready  (w_irdy[k]),
            .ifu_req_addr   (ia),
            .ifu_resp_valid (w_ivld[k]),
            .ifu_resp_ready (irr && (sel == 2'(k))),
            .ifu_resp_data  (w_idata[k]),
            .lsu_req_valid  (lv && (sel == 2'(k))),
            .lsu_req_ready  (w_lrdy[k]),
            .lsu_req_addr   (la),
            .lsu_req_wen    (lw),
            .lsu_req_wmask  (lm),
            .lsu_req_wdata  (ld),
            .lsu_resp_valid (w_lvld[k]),
            .lsu_resp_ready (lrr && (sel == 2'(k))),
            .lsu_resp_data  (w_ldata[k]),
            .mem_ren        (w_ren[k]),
            .mem_wen        (w_wen[k]),
            .mem_addr       (w_addr[k]),
            .mem_wmask      (w_wmask[k]),
            .mem_wdata      (w_wdata[k]),
            .mem_rdata      (w_rdata[k])
        );
        assign w_rdata[k] = mem[w_addr[k][15:3]];
    end

    always @(posedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (w_wen[k])
                for (int b = 0; b < 8; b++)
                    if (w_wmask[k][b]) mem[w_addr[k][15:3]][8*b +: 8] <= w_wdata[k][8*b +: 8];
            if (w_ren[k] || w_wen[k]) strobes[k] <= strobes[k] + 1;
        end
    end

    always_comb begin
        o_irdy  = w_irdy[sel];
        o_lrdy  = w_lrdy[sel];
        o_ivld  = w_ivld[sel];
        o_lvld  = w_lvld[sel];
        o_ren   = w_ren[sel];
        o_wen   = w_wen[sel];
        o_idata = w_idata[sel];
        o_ldata = w_ldata[sel];
        o_addr  = w_addr[sel];
        o_wdata = w_wdata[sel];
        o_wmask = w_wmask[sel];
    end

    typedef struct {
        string       name;
        logic [1:0]  inst;
        logic        iv;
        logic [63:0] ia;
        logic        lv;
        logic        lw;
        logic [63:0] la;
        logic [7:0]  lm;
        logic [63:0] ld;
        logic [1:0]  e_rdy;   // {ifu, lsu}
        logic [1:0]  e_stb;   // {ren, wen}
        logic [1:0]  e_vld;   // {ifu, lsu}
        logic [63:0] e_data;
        logic [63:0] e_addr;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [1:0] inst,
                                input logic iv_, input logic [63:0] ia_,
                                input logic lv_, input logic lw_, input logic [63:0] la_,
                                input logic [7:0] lm_, input logic [63:0] ld_,
                                input logic [1:0] rdy, input logic [1:0] stb, input logic [1:0] vld,
                                input logic [63:0] dat, input logic [63:0] adr,
                                input logic [7:0] msk, input logic [63:0] wd);
        vec_t v;
        v.name = nm; v.inst = inst; v.iv = iv_; v.ia = ia_; v.lv = lv_; v.lw = lw_;
        v.la = la_; v.lm = lm_; v.ld = ld_; v.e_rdy = rdy; v.e_stb = stb; v.e_vld = vld;
        v.e_data = dat; v.e_addr = adr; v.e_mask = msk; v.e_wdata = wd;
        return v;
    endfunction

    function automatic vec_t idle(input string nm, input logic [1:0] inst);
        return mk(nm, inst, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s, input logic iv_, input logic [63:0] ia_,
                         input logic lv_, input logic lw_, input logic [63:0] la_,
                         input logic [7:0] lm_, input logic [63:0] ld_);
        sel = s; iv = iv_; ia = ia_; lv = lv_; lw = lw_; la = la_; lm = lm_; ld = ld_;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic apply(input vec_t v);
        drive(v.inst, v.iv, v.ia, v.lv, v.lw, v.la, v.lm, v.ld);
        #2;
        chk({v.name, ".rdy"}, 64'({o_irdy, o_lrdy}), 64'(v.e_rdy));
        chk({v.name, ".stb"}, 64'({o_ren, o_wen}), 64'(v.e_stb));
        chk({v.name, ".vld"}, 64'({o_ivld, o_lvld}), 64'(v.e_vld));
        if (v.e_vld[1]) chk({v.name, ".idata"}, o_idata, v.e_data);
        if (v.e_vld[0]) chk({v.name, ".ldata"}, o_ldata, v.e_data);
        if (v.e_stb != 2'b00) begin
            chk({v.name, ".addr"}, o_addr, v.e_addr);
            chk({v.name, ".wmask"}, 64'(o_wmask), 64'(v.e_mask));
            chk({v.name, ".wdata"}, o_wdata, v.e_wdata);
        end
        next_cycle();
    endtask

    localparam logic [63:0] BOOT = 64'h0000_0413_0000_0297;
    localparam logic [63:0] RDW  = 64'hDEAD_BEEF_CAFE_F00D;

    initial begin
        vec_t tbl[$];
        bit   lsu_win;
        int   s0;

        for (int i = 0; i < 8192; i++) mem[i] = '0;
        mem[0] = BOOT;
        irr = 1'b1; lrr = 1'b1;
        drive(2'd0, 1'b1, 64'h8000_0000, 1'b1, 1'b0, 64'h8000_1000, '0, '0);

        // Outputs must be zero while held in reset, even with valid requests.
        #3;
        chk("rst.ctrl", 64'({o_irdy, o_lrdy, o_ivld, o_lvld, o_ren, o_wen}), '0);
        chk("rst.addr", o_addr, '0);
        chk("rst.data", o_idata, '0);
        @(posedge clock);
        next_cycle();
        reset_n = 1'b1;
        drive(2'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        // IFU read, LATENCY 0
        tbl.push_back(mk("A.acc", 2'd0, 1'b1, 64'h8000_0000, 1'b0, 1'b0, '0, '0, '0, 2'b10, 2'b00, 2'b00, '0, '0, '0, '0));
        tbl.push_back(mk("A.mem", 2'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b10, 2'b00, '0, 64'h8000_0000, '0, '0));
        tbl.push_back(mk("A.rsp", 2'd0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b00, 2'b10, BOOT, '0, '0, '0));
        tbl.push_back(idle("A.idle", 2'd0));
        // LSU write then readback, LATENCY 3
        tbl.push_back(mk("B.acc", 2'd2, 1'b0, '0, 1'b1, 1'b1, 64'h8000_1000, 8'h0F, 64'h1122_3344, 2'b01, 2'b00, 2'b00, '0, '0, '0, '0));
        tbl.push_back(idle("B.w1", 2'd2));
        tbl.push_back(idle("B.w2", 2'd2));
        tbl.push_back(idle("B.w3", 2'd2));
        tbl.push_back(mk("B.mem", 2'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b01, 2'b00, '0, 64'h8000_1000, 8'h0F, 64'h1122_3344));
        tbl.push_back(mk("B.rsp", 2'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b00, 2'b01, '0, '0, '0, '0));
        tbl.push_back(mk("B.racc", 2'd2, 1'b0, '0, 1'b1, 1'b0, 64'h8000_1000, '0, '0, 2'b01, 2'b00, 2'b00, '0, '0, '0, '0));
        tbl.push_back(idle("B.rw1", 2'd2));
        tbl.push_back(idle("B.rw2", 2'd2));
        tbl.push_back(idle("B.rw3", 2'd2));
        tbl.push_back(mk("B.rmem", 2'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b10, 2'b00, '0, 64'h8000_1000, '0, '0));
        tbl.push_back(mk("B.rrsp", 2'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b00, 2'b01, 64'h1122_3344, '0, '0, '0));
        // LSU write then IFU read of the same word, LATENCY 1; IFU waits through the RESP cycle
        tbl.push_back(mk("D.acc", 2'd1, 1'b0, '0, 1'b1, 1'b1, 64'h8000_0010, 8'hFF, RDW, 2'b01, 2'b00, 2'b00, '0, '0, '0, '0));
        tbl.push_back(idle("D.w", 2'd1));
        tbl.push_back(mk("D.mem", 2'd1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b01, 2'b00, '0, 64'h8000_0010, 8'hFF, RDW));
        tbl.push_back(mk("D.rsp", 2'd1, 1'b1, 64'h8000_0010, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b00, 2'b01, '0, '0, '0, '0));
        tbl.push_back(mk("D.racc", 2'd1, 1'b1, 64'h8000_0010, 1'b0, 1'b0, '0, '0, '0, 2'b10, 2'b00, 2'b00, '0, '0, '0, '0));
        tbl.push_back(idle("D.rw", 2'd1));
        tbl.push_back(mk("D.rmem", 2'd1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b10, 2'b00, '0, 64'h8000_0010, '0, '0));
        tbl.push_back(mk("D.rrsp", 2'd1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 2'b00, 2'b10, RDW, '0, '0, '0));
        // Both requesters valid for 4 back-to-back transactions, LATENCY 0
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
            lsu_win = (t % 2) == 0;
`else
            lsu_win = 1'b1;
`endif
            tbl.push_back(mk($sformatf("C%0d.acc", t), 2'd0, 1'b1, 64'h8000_0000, 1'b1, 1'b0, 64'h8000_1000, '0, '0,
                             lsu_win ? 2'b01 : 2'b10, 2'b00, 2'b00, '0, '0, '0, '0));
            tbl.push_back(mk($sformatf("C%0d.mem", t), 2'd0, 1'b1, 64'h8000_0000, 1'b1, 1'b0, 64'h8000_1000, '0, '0,
                             2'b00, 2'b10, 2'b00, '0, lsu_win ? 64'h8000_1000 : 64'h8000_0000, '0, '0));
            tbl.push_back(mk($sformatf("C%0d.rsp", t), 2'd0, 1'b1, 64'h8000_0000, 1'b1, 1'b0, 64'h8000_1000, '0, '0,
                             2'b00, 2'b00, lsu_win ? 2'b01 : 2'b10, lsu_win ? 64'h1122_3344 : BOOT, '0, '0, '0));
        end
        tbl.push_back(idle("C.idle", 2'd0));

        foreach (tbl[i]) apply(tbl[i]);

        // Response backpressure on LSU, LATENCY 3
        s0 = strobes[2];
        lrr = 1'b0;
        drive(2'd2, 1'b0, '0, 1'b1, 1'b0, 64'h8000_1000, '0, '0);
        #2 chk("E.acc", 64'(o_lrdy), 64'd1);
        next_cycle();
        drive(2'd2, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) next_cycle();
        for (int c = 0; c < 5; c++) begin
            iv = 1'b1; ia = 64'h8000_0000;
            #2;
            chk($sformatf("E.hold%0d.vld", c), 64'({o_ivld, o_lvld}), 64'd1);
            chk($sformatf("E.hold%0d.data", c), o_ldata, 64'h1122_3344);
            chk($sformatf("E.hold%0d.rdy_stb", c), 64'({o_irdy, o_lrdy, o_ren, o_wen}), '0);
            next_cycle();
        end
        iv = 1'b0; lrr = 1'b1;
        #2 chk("E.hs.vld", 64'(o_lvld), 64'd1);
        next_cycle();
        #2 chk("E.idle.vld", 64'({o_ivld, o_lvld}), '0);
        chk("E.strobes", 64'(strobes[2] - s0), 64'd1);
        next_cycle();

        // Reset during WAIT, LATENCY 5: no strobe, then a clean IFU read
        s0 = strobes[3];
        drive(2'd3, 1'b0, '0, 1'b1, 1'b1, 64'h8000_2000, 8'hFF, 64'h55);
        #2 chk("F.acc", 64'(o_lrdy), 64'd1);
        next_cycle();
        drive(2'd3, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        next_cycle();
        iv = 1'b1; ia = 64'h8000_0000;
        reset_n = 1'b0;
        #1;
        chk("F.rst.ctrl", 64'({o_irdy, o_lrdy, o_ivld, o_lvld, o_ren, o_wen}), '0);
        chk("F.rst.addr", o_addr, '0);
        chk("F.rst.wd", o_wdata, '0);
        chk("F.rst.wm", 64'(o_wmask), '0);
        @(posedge clock);
        next_cycle();
        reset_n = 1'b1; iv = 1'b0;
        repeat (8) next_cycle();
        chk("F.nostrobe", 64'(strobes[3] - s0), '0);
        chk("F.memclean", mem[13'h400], '0);
        iv = 1'b1; ia = 64'h8000_0000;
        #2 chk("F.racc", 64'({o_irdy, o_lrdy}), 64'b10);
        next_cycle();
        iv = 1'b0;
        repeat (5) next_cycle();
        #2 chk("F.rmem", 64'({o_ren, o_wen}), 64'b10);
        next_cycle();
        #2;
        chk("F.rrsp.vld", 64'({o_ivld, o_lvld}), 64'b10);
        chk("F.rrsp.data", o_idata, BOOT);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single DPI-backed virtual memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Accepts one request at a time and inserts a programmable access latency.
- Fires the memory strobes for exactly one cycle per transaction, so DPI reads/writes execute once.
- Returns the result to the owning requester over a valid/ready response channel.

Parameters:
- LATENCY, 0, extra wait cycles between request accept and memory access; legal range 0..255, held in an 8-bit counter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  64  IFU read address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU consumes response
- ifu_resp_data  out  64  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  64  LSU address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wmask  in  8  byte write mask
- lsu_req_wdata  in  64  write data
- lsu_resp_valid  out  1  LSU response or write ack available
- lsu_resp_ready  in  1  LSU consumes response
- lsu_resp_data  out  64  LSU read data; 0 for writes
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- mem_addr  out  64  memory address
- mem_wmask  out  8  memory write mask
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, combinational from mem_addr while mem_ren = 1

Behaviour:
- States: IDLE, WAIT, ACCESS, RESP. Registers: owner (IFU/LSU), addr, wen, wmask, wdata, rdata, cnt[7:0], last_grant.
- Reset (reset_n low, asynchronous):
  - state = IDLE, all registers 0, last_grant = IFU.
  - All outputs 0, including the ready, resp_valid and strobe signals.
  - A transaction in flight is dropped with no strobe and no response.
- IDLE:
  - Grant is computed combinationally from the valids.
  - The granted requester's req_ready = 1; the other's req_ready = 0. Both are 0 if neither requester is valid.
  - On valid & ready: capture the request. A captured IFU request sets wen = 0 and wmask = 0.
  - Next state: WAIT with cnt = LATENCY-1 if LATENCY > 0; ACCESS if LATENCY = 0.
- WAIT: cnt decrements each cycle; when cnt = 0, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_ren = ~wen and mem_wen = wen.
  - rdata <= mem_rdata on a read, or 0 on a write.
  - Next state: RESP.
- RESP:
  - The owner's resp_valid = 1 and resp_data = rdata, both stable until the owner's resp_ready.
  - On handshake: go to IDLE. A new request is not accepted in the same cycle as the handshake.
- Strobe rules:
  - mem_ren and mem_wen are 0 in every state except ACCESS; they are never both 1.
  - mem_addr, mem_wmask and mem_wdata always reflect the captured registers.
- Latency: accept at cycle T -> ACCESS at T+1+LATENCY -> resp_valid at T+2+LATENCY.
- Requests are not accepted while the block is outside IDLE; req_ready = 0 in WAIT, ACCESS and RESP.
- The non-granted requester must hold valid; its request is serviced after the current transaction completes.
- The non-owner's resp_valid is always 0.
- last_grant updates on every accept.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are valid in IDLE, grant goes to the requester not equal to last_grant. A single valid requester is always granted.
- Undefined: fixed priority, LSU over IFU. last_grant is still maintained but unused.

Test Plan:
- LATENCY=0, IFU read addr 0x80000000, memory holds 0x00000413_00000297:
  - ifu_req_ready at T; mem_ren high for exactly one cycle at T+1.
  - ifu_resp_valid at T+2 with data 0x00000413_00000297; lsu_resp_valid stays 0.
- LATENCY=3, LSU write addr 0x80001000, wmask 0x0F, wdata 0x11223344:
  - mem_wen is a single pulse at T+4 with the captured values.
  - lsu_resp_valid at T+5 with data 0.
  - Readback via an LSU read returns 0x11223344 in the low word.
- Both requesters valid in the same cycle, repeated for 4 transactions:
  - Without MEM_ARB_RR_EN, LSU wins every time while it stays valid.
  - With the macro, grants alternate LSU, IFU, LSU, IFU (starting from last_grant = IFU).
- Response backpressure: hold lsu_resp_ready = 0 for 5 cycles:
  - resp_valid and data stay stable; no new req_ready; no further mem strobes.
  - Handshake on cycle 6 returns the block to IDLE.
- Reset mid-operation: assert reset_n low during WAIT (LATENCY=5):
  - All outputs drop to 0 immediately.
  - No mem_ren/mem_wen pulse occurs.
  - After release, the next request completes normally.
- Read during write: LSU write to 0x80000010, then IFU read of 0x80000010 with LATENCY=1:
  - The IFU response returns the newly written data, since transactions are strictly serialized.
